// File: rtl/retospect_lif_neuron.sv
//-----------------------------------------------------------------------------
// retospect_lif_neuron
//
// Leaky integrate-and-fire neuron cell for the neurochip array.
//
// Each run cycle the membrane potential is optionally leaked (when the
// selected clockbox strobe is high). Then the signed weights of every active
// dendrite are added. The result is clamped to the unsigned potential range
// and compared against a programmable threshold. A fire emits a one-cycle
// axon pulse, zeroes the potential and, when refrac is nonzero, blocks the
// cell for refrac cycles.
//
// Configuration is held in a serial shift chain shared with the neighbouring
// cells. cfg <= {bs_in, cfg[CFG_BITS-1:1]}, and bs_out = cfg[0].
//
// Timing contract (there is no valid/ready handshake; the cell is fully
// pipelined at one update per clock):
//   - dendrite and clockbus are sampled at edge N.
//   - potential and axon reflect that sample after edge N.
//   - bs_out moves only on cycles with config_en high.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high; clears everything including cfg
//   reset_nn   network soft reset; clears dynamic state, keeps cfg
//   config_en  shift the configuration chain this cycle
//   bs_in      bitstream serial input
//   bs_out     bitstream serial output (cfg[0])
//   clockbus   decay strobes from the clockbox, indexed by decay_sel
//   dendrite   synaptic spike inputs
//   axon       registered spike output
//   potential  registered membrane potential
//   state_dbg  current FSM state (1 = refractory), for observation
//-----------------------------------------------------------------------------
module retospect_lif_neuron #(
   parameter int NUM_DENDRITES   = 4,
   parameter int W_WIDTH         = 4,
   parameter int POT_WIDTH       = 8,
   parameter int DECAY_SEL_WIDTH = 3,
   parameter int REFRAC_WIDTH    = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              reset_nn,
   input  logic                              config_en,
   input  logic                              bs_in,
   output logic                              bs_out,
   input  logic [(2**DECAY_SEL_WIDTH)-1:0]   clockbus,
   input  logic [NUM_DENDRITES-1:0]          dendrite,
   output logic                              axon,
   output logic [POT_WIDTH-1:0]              potential,
   output logic                              state_dbg
);

   localparam int CFG_BITS = NUM_DENDRITES*W_WIDTH + POT_WIDTH + 2
                             + DECAY_SEL_WIDTH + REFRAC_WIDTH;
   localparam int TH_LSB   = NUM_DENDRITES*W_WIDTH;
   localparam int LM_LSB   = TH_LSB + POT_WIDTH;
   localparam int DS_LSB   = LM_LSB + 2;
   localparam int RF_LSB   = DS_LSB + DECAY_SEL_WIDTH;
   // Wide enough for the leaked potential plus every dendrite at its most
   // extreme weight, with a sign bit.
   localparam int SUM_W    = POT_WIDTH + $clog2(NUM_DENDRITES) + W_WIDTH + 1;

   localparam logic [POT_WIDTH-1:0]    POT_ONE = POT_WIDTH'(1);
   localparam logic [REFRAC_WIDTH-1:0] RF_ONE  = REFRAC_WIDTH'(1);

   typedef enum logic {
      ST_INTEGRATE  = 1'b0,
      ST_REFRACTORY = 1'b1
   } state_t;

   //--------------------------------------------------------------------------
   // Registers
   //--------------------------------------------------------------------------
   logic [CFG_BITS-1:0]     cfg_q,   cfg_d;
   state_t                  state_q, state_d;
   logic [REFRAC_WIDTH-1:0] cnt_q,   cnt_d;
   logic [POT_WIDTH-1:0]    pot_q,   pot_d;
   logic                    axon_q,  axon_d;

   //--------------------------------------------------------------------------
   // Configuration fields
   //--------------------------------------------------------------------------
   logic [POT_WIDTH-1:0]       threshold;
   logic [1:0]                 leak_mode;
   logic [DECAY_SEL_WIDTH-1:0] decay_sel;
   logic [REFRAC_WIDTH-1:0]    refrac;

   assign threshold = cfg_q[TH_LSB +: POT_WIDTH];
   assign leak_mode = cfg_q[LM_LSB +: 2];
   assign decay_sel = cfg_q[DS_LSB +: DECAY_SEL_WIDTH];
   assign refrac    = cfg_q[RF_LSB +: REFRAC_WIDTH];

   //--------------------------------------------------------------------------
   // Leak: applied only when the selected clockbox strobe is high
   //--------------------------------------------------------------------------
   logic [POT_WIDTH-1:0] leaked;

   always_comb begin
      leaked = pot_q;
      if (clockbus[decay_sel]) begin
         case (leak_mode)
            2'b01:   leaked = pot_q >> 1;
            2'b10:   leaked = (pot_q == '0) ? '0 : (pot_q - POT_ONE);
            2'b11:   leaked = '0;
            default: leaked = pot_q;
         endcase
      end
   end

   //--------------------------------------------------------------------------
   // Dendrite accumulation: every active dendrite contributes in the same cycle
   //--------------------------------------------------------------------------
   logic signed [SUM_W-1:0] sum;

   always_comb begin
      sum = $signed({{(SUM_W-POT_WIDTH){1'b0}}, leaked});
      for (int i = 0; i < NUM_DENDRITES; i++) begin
         if (dendrite[i]) begin
            sum = sum + $signed({{(SUM_W-W_WIDTH){cfg_q[i*W_WIDTH + W_WIDTH - 1]}},
                                 cfg_q[i*W_WIDTH +: W_WIDTH]});
         end
      end
   end

   //--------------------------------------------------------------------------
   // Clamp to [0, 2**POT_WIDTH-1] and decide whether to fire
   //--------------------------------------------------------------------------
   logic [POT_WIDTH-1:0] clamped;
   logic                 fire;

   always_comb begin
      if (sum[SUM_W-1]) begin
         clamped = '0;
      end else if (|sum[SUM_W-2:POT_WIDTH]) begin
         clamped = '1;
      end else begin
         clamped = sum[POT_WIDTH-1:0];
      end
   end

   // A zero threshold disables firing; integration continues regardless.
   assign fire = (threshold != '0) && (clamped >= threshold);

   //--------------------------------------------------------------------------
   // Next-state logic. Priority: reset_nn > config_en > run.
   // reset is handled in the register process.
   //--------------------------------------------------------------------------
   always_comb begin
      cfg_d   = cfg_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      pot_d   = pot_q;
      axon_d  = 1'b0;

      if (reset_nn) begin
         pot_d   = '0;
         state_d = ST_INTEGRATE;
         cnt_d   = '0;
      end else if (config_en) begin
         // Dynamic state freezes while the chain shifts.
         cfg_d = {bs_in, cfg_q[CFG_BITS-1:1]};
      end else begin
         case (state_q)
            ST_INTEGRATE: begin
               if (fire) begin
                  pot_d  = '0;
                  axon_d = 1'b1;
                  if (refrac != '0) begin
                     state_d = ST_REFRACTORY;
                     cnt_d   = refrac;
                  end
               end else begin
                  pot_d = clamped;
               end
            end
            ST_REFRACTORY: begin
               // The counter was latched at fire time, so cfg edits made
               // during config_en cycles cannot stretch or cut this period.
               pot_d = '0;
               cnt_d = cnt_q - RF_ONE;
               if (cnt_q <= RF_ONE) begin
                  state_d = ST_INTEGRATE;
               end
            end
            default: begin
               state_d = ST_INTEGRATE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   //--------------------------------------------------------------------------
   // State register
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_q   <= '0;
         state_q <= ST_INTEGRATE;
         cnt_q   <= '0;
         pot_q   <= '0;
         axon_q  <= 1'b0;
      end else begin
         cfg_q   <= cfg_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pot_q   <= pot_d;
         axon_q  <= axon_d;
      end
   end

   assign bs_out    = cfg_q[0];
   assign axon      = axon_q;
   assign potential = pot_q;
   assign state_dbg = (state_q == ST_REFRACTORY);

endmodule

// File: tb/tb_retospect_lif_neuron.sv
//-----------------------------------------------------------------------------
// Testbench for retospect_lif_neuron (default parameters).
// The driver issues one cycle at a time and advances a behavioural model.
// After each clock edge, the driver pushes the model's predicted outputs into
// exp_q. A monitor pops one entry per falling edge and compares it with the
// DUT. Directed sequences from the cell's documented behaviour are followed
// by randomized traffic.
//-----------------------------------------------------------------------------
module tb_retospect_lif_neuron;

   localparam int ND  = 4;
   localparam int PW  = 8;
   localparam int CBW = 8;
   localparam int EW  = 3 + PW;   // {state, bs_out, axon, potential}

   // clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset = 1'b1;
   logic           reset_nn = 1'b0;
   logic           config_en = 1'b0;
   logic           bs_in = 1'b0;
   logic [CBW-1:0] clockbus = '0;
   logic [ND-1:0]  dendrite = '0;
   logic           bs_out;
   logic           axon;
   logic [PW-1:0]  potential;
   logic           state_dbg;

   retospect_lif_neuron dut (
      .clk       (clk),
      .reset     (reset),
      .reset_nn  (reset_nn),
      .config_en (config_en),
      .bs_in     (bs_in),
      .bs_out    (bs_out),
      .clockbus  (clockbus),
      .dendrite  (dendrite),
      .axon      (axon),
      .potential (potential),
      .state_dbg (state_dbg)
   );

   // scoreboard
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [EW-1:0] e;
         e = exp_q.pop_front();
         chk("potential", int'(potential), int'(e[PW-1:0]));
         chk("axon",      int'(axon),      int'(e[PW]));
         chk("bs_out",    int'(bs_out),    int'(e[PW+1]));
         chk("state",     int'(state_dbg), int'(e[PW+2]));
      end
   end

   // behavioural model: cfg as a plain word, potential and blocked cycles as ints
   logic [31:0] m_cfg  = '0;
   int          m_pot  = 0;
   int          m_left = 0;
   int          m_axon = 0;

   function automatic int wgt(input logic [31:0] c, input int i);
      int v;
      v = int'((c >> (4*i)) & 32'hF);
      if (v >= 8) v -= 16;
      return v;
   endfunction

   task automatic model_step();
      int thr, lm, ds, rf, leaked, total;
      thr = int'((m_cfg >> 16) & 32'hFF);
      lm  = int'((m_cfg >> 24) & 32'h3);
      ds  = int'((m_cfg >> 26) & 32'h7);
      rf  = int'((m_cfg >> 29) & 32'h7);
      if (reset) begin
         m_cfg = '0; m_pot = 0; m_left = 0; m_axon = 0;
      end else if (reset_nn) begin
         m_pot = 0; m_left = 0; m_axon = 0;
      end else if (config_en) begin
         m_cfg = {bs_in, m_cfg[31:1]};
         m_axon = 0;
      end else if (m_left > 0) begin
         m_left--; m_pot = 0; m_axon = 0;
      end else begin
         leaked = m_pot;
         if (clockbus[ds]) begin
            if (lm == 1) leaked = m_pot / 2;
            else if (lm == 2) leaked = (m_pot > 0) ? m_pot - 1 : 0;
            else if (lm == 3) leaked = 0;
         end
         total = leaked;
         for (int i = 0; i < ND; i++) if (dendrite[i]) total += wgt(m_cfg, i);
         if (total < 0) total = 0;
         if (total > 255) total = 255;
         if (thr != 0 && total >= thr) begin
            m_pot = 0; m_axon = 1; m_left = rf;
         end else begin
            m_pot = total; m_axon = 0;
         end
      end
   endtask

   // driver tasks
   task automatic step(input logic rst, input logic rnn, input logic cen,
                       input logic bs, input logic [ND-1:0] dend,
                       input logic [CBW-1:0] cb);
      logic [PW-1:0] p;
      reset = rst; reset_nn = rnn; config_en = cen; bs_in = bs;
      dendrite = dend; clockbus = cb;
      model_step();
      @(posedge clk);
      p = PW'(m_pot);
      exp_q.push_back({(m_left > 0), m_cfg[0], (m_axon != 0), p});
      #1;
   endtask

   task automatic load_cfg(input logic [31:0] v);
      for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, v[i], '0, '0);
   endtask

   task automatic idle(input logic [ND-1:0] dend, input logic [CBW-1:0] cb);
      step(1'b0, 1'b0, 1'b0, 1'b0, dend, cb);
   endtask

   localparam logic [31:0] CFG_MAIN = 32'h400A7F23;

   initial begin
      logic [31:0] obs;
      int exp_pot[8];
      int exp_ax[8];
      int leak_pot[5];
      int seen_axon;

      // reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("reset_potential", int'(potential), 0);
      chk("reset_bs_out", int'(bs_out), 0);

      // config round trip: the second pass shifts the same word so cfg is kept
      load_cfg(CFG_MAIN);
      obs = '0;
      for (int i = 0; i < 32; i++) begin
         obs[i] = bs_out;
         step(1'b0, 1'b0, 1'b1, CFG_MAIN[i], '0, '0);
      end
      chk("bs_roundtrip", int'(obs), int'(CFG_MAIN));

      // integrate and fire with w0=3, threshold 10, refrac 2
      exp_pot = '{3, 6, 9, 0, 0, 0, 3, 6};
      exp_ax  = '{0, 0, 0, 1, 0, 0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         idle(4'b0001, '0);
         chk("fire_seq_pot", int'(potential), exp_pot[i]);
         chk("fire_seq_axon", int'(axon), exp_ax[i]);
      end

      // inhibition floors at 0; all dendrites together fire in one cycle
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      idle(4'b0100, '0);
      chk("inhibit_floor", int'(potential), 0);
      idle(4'b1111, '0);
      chk("simul_fire_axon", int'(axon), 1);
      chk("simul_fire_pot", int'(potential), 0);
      idle('0, '0);
      idle('0, '0);

      // soft reset during refractory, then a one-cycle config hold
      for (int i = 0; i < 4; i++) idle(4'b0001, '0);
      chk("sr_fire", int'(axon), 1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, '0);
      chk("sr_state", int'(state_dbg), 0);
      idle(4'b0001, '0);
      chk("sr_accept", int'(potential), 3);
      idle(4'b0001, '0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, '0);
      chk("cfg_hold_pot", int'(potential), 6);
      chk("cfg_hold_axon", int'(axon), 0);

      // saturation with firing disabled
      load_cfg(32'h00007000);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      seen_axon = 0;
      for (int i = 0; i < 40; i++) begin
         idle(4'b1000, '0);
         if (axon) seen_axon = 1;
      end
      chk("sat_pot", int'(potential), 255);
      chk("sat_no_axon", seen_axon, 0);

      // leak mode 01 on clockbus[1]
      load_cfg(32'h050A0003);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      leak_pot = '{3, 4, 5, 5, 5};
      for (int i = 0; i < 5; i++) begin
         idle(4'b0001, 8'b0000_0010);
         chk("leak_pot", int'(potential), leak_pot[i]);
         chk("leak_axon", int'(axon), 0);
      end

      // randomized traffic
      for (int seg = 0; seg < 8; seg++) begin
         logic [31:0] c;
         c = $urandom();
         c[23:16] = 8'($urandom_range(0, 40));
         load_cfg(c);
         for (int i = 0; i < 200; i++) begin
            logic rnn, cen;
            rnn = ($urandom_range(0, 99) < 2);
            cen = ($urandom_range(0, 99) < 3);
            step(1'b0, rnn, cen, 1'($urandom_range(0, 1)),
                 ND'($urandom_range(0, 15)), CBW'($urandom_range(0, 255)));
         end
      end

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/retospect_lif_neuron.md
# retospect_lif_neuron

Parametrised leaky integrate-and-fire neuron cell, the next-generation replacement for the fixed 4-dendrite/3-bit-weight cell in the neurochip array. It adds a configurable dendrite count, signed (inhibitory) weights, a programmable firing threshold, selectable leak modes and a refractory period. Configuration stays on the shared serial bitstream chain. Decay timing still comes from the existing clockbox bus.

## Interface
Parameters:
- NUM_DENDRITES, 4, number of dendrite inputs (1..8)
- W_WIDTH, 4, per-dendrite weight width, two's complement
- POT_WIDTH, 8, membrane potential width, unsigned
- DECAY_SEL_WIDTH, 3, width of the clockbus select field; clockbus width is 2**DECAY_SEL_WIDTH
- REFRAC_WIDTH, 3, width of the refractory-length field
- Derived: CFG_BITS = NUM_DENDRITES*W_WIDTH + POT_WIDTH + 2 + DECAY_SEL_WIDTH + REFRAC_WIDTH (32 at defaults)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clears everything, including configuration
- reset_nn  in  1  network soft reset; clears dynamic state, keeps configuration
- config_en  in  1  shift the configuration chain this cycle
- bs_in  in  1  bitstream serial input
- bs_out  out  1  bitstream serial output, = cfg[0]
- clockbus  in  2**DECAY_SEL_WIDTH  decay strobes from the clockbox
- dendrite  in  NUM_DENDRITES  synaptic spike inputs
- axon  out  1  registered spike output
- potential  out  POT_WIDTH  registered membrane potential (debug/observation)

## Operation
- Configuration register cfg[CFG_BITS-1:0], fields listed from the LSB:
  - weight i at [i*W_WIDTH +: W_WIDTH]
  - threshold (POT_WIDTH bits)
  - leak_mode (2 bits)
  - decay_sel (DECAY_SEL_WIDTH bits)
  - refrac (REFRAC_WIDTH bits)
- Default layout: w0 [3:0], w1 [7:4], w2 [11:8], w3 [15:12], threshold [23:16], leak_mode [25:24], decay_sel [28:26], refrac [31:29].
- Shift rule: cfg <= {bs_in, cfg[CFG_BITS-1:1]}. The first bit shifted in lands at cfg[0] after CFG_BITS shifts.
- Priority each cycle: reset > reset_nn > config_en > run.
- reset: cfg=0, potential=0, axon=0, state=INTEGRATE, refractory counter=0.
- reset_nn: potential=0, axon=0, state=INTEGRATE, counter=0; cfg held.
- config_en: shift cfg; potential, state and counter held; axon<=0.
- State machine: INTEGRATE, REFRACTORY.
- INTEGRATE, each run cycle:
  - leaked = potential if clockbus[decay_sel]==0. Otherwise by leak_mode: 00 potential; 01 potential>>1; 10 potential-1, floored at 0; 11 zero.
  - sum = leaked + sign-extended weights of all active dendrites, computed in POT_WIDTH+$clog2(NUM_DENDRITES)+W_WIDTH+1 signed bits. All simultaneous dendrites are accumulated.
  - next = sum clamped to [0, 2**POT_WIDTH-1].
  - Fire if threshold != 0 and next >= threshold: potential<=0, axon<=1. If refrac != 0, go to REFRACTORY with counter<=refrac.
  - No fire: potential<=next, axon<=0.
  - threshold==0 disables firing; the potential still integrates and saturates.
- REFRACTORY:
  - dendrites and leak ignored; potential held at 0; axon<=0.
  - counter decrements; when counter==1, next state is INTEGRATE.
  - refrac=R blocks exactly R cycles.
- refrac or cfg changes made via config_en during REFRACTORY do not alter the running counter.

## Timing
- Dendrite and clockbus are sampled at edge N. The potential update and axon appear after edge N, so latency from input to axon is 1 cycle.
- axon is high for exactly one cycle per fire and never on two consecutive cycles when refrac>0.
- refrac=0: back-to-back fires are allowed (axon may stay high).
- bs_out changes only on config_en cycles; chain delay through the cell is CFG_BITS cycles.
- Reset values: axon=0, potential=0, bs_out=0.

## Test plan
- Config round-trip: reset, then shift 0x400A7F23 LSB-first over 32 cycles, then 32 more cycles. bs_out must reproduce 0x400A7F23 LSB-first. Decoded fields: w0=3, w1=2, w2=-1, w3=7, threshold=10, leak 00, decay_sel 0, refrac 2.
- Integrate and fire (cfg above, dendrite=4'b0001 held): potential 3, 6, 9; on the 4th cycle axon=1 and potential=0. Then 2 refractory cycles with potential=0. Then 3, 6, ...
- Simultaneous/inhibit (cfg above): dendrite=4'b0100 from 0 keeps potential at 0 (floor). dendrite=4'b1111 from 0 gives sum 11 and fires in one cycle.
- Saturation/disable: threshold=0, w3=7, dendrite[3] held: potential climbs 7, 14, ... 252, then 255 and holds; axon never rises.
- Leak: leak_mode=01, decay_sel=1 (clockbus[1]=1), w0=3, dendrite[0] held: potential 3, 4, 5, 5, 5; no fire at threshold 10.
- Soft reset/config hold: assert reset_nn during refractory cycle 1. Next cycle state=INTEGRATE, potential=0, dendrite[0] accepted (potential=3), cfg unchanged. Then config_en for 1 cycle at potential=6: potential holds 6 and axon=0.
